// File: rtl/spi_sinecfg_pkg.sv
// Shared constants, register map and FSM encoding for the SPI sine-generator
// configuration port.
package spi_sinecfg_pkg;

  localparam logic [6:0]  ADDR_STEP  = 7'h00;
  localparam logic [6:0]  ADDR_SCALE = 7'h01;
  localparam logic [6:0]  ADDR_ID    = 7'h7F;
  localparam logic [15:0] ID_VALUE   = 16'h5A1E;

  localparam logic [4:0]  FRAME_BITS = 5'd24;
  localparam logic [4:0]  HDR_BITS   = 5'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HDR  = 2'b01,
    ST_DATA = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  // Read-back view of the register map; unmapped addresses read as zero.
  function automatic logic [15:0] reg_read(input logic [6:0]  addr,
                                           input logic [15:0] step,
                                           input logic [1:0]  scale);
    case (addr)
      ADDR_STEP:  reg_read = step;
      ADDR_SCALE: reg_read = {14'h0000, scale};
      ADDR_ID:    reg_read = ID_VALUE;
      default:    reg_read = 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/spi_sinecfg_sync_edge.sv
// Two-flop synchronizer followed by a third flop used purely for edge
// detection; level and edge outputs are therefore mutually aligned.
module sync_edge
  import spi_sinecfg_pkg::*;
#(
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic meta_r;
  logic sync_r;
  logic prev_r;

  // Synchronizer chain plus delayed copy for edge compare; resets to idle level.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      meta_r <= IDLE_LVL;
      sync_r <= IDLE_LVL;
      prev_r <= IDLE_LVL;
    end else begin
      meta_r <= i_async;
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  assign o_level = sync_r;
  assign o_rise  = sync_r & ~prev_r;
  assign o_fall  = ~sync_r & prev_r;

endmodule

// File: rtl/spi_sinecfg.sv
// SPI mode-0 slave that configures the phase step and amplitude scale of a
// downstream sine generator. Frames are 24 bits: 8-bit header (R/W + 7-bit
// address) followed by 16 data bits, MSB first.
module spi_sinecfg
  import spi_sinecfg_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_spi_cs_n,
  input  logic        i_spi_sck,
  input  logic        i_spi_mosi,
  output logic        o_spi_miso,
  output logic [15:0] o_step,
  output logic [1:0]  o_scale,
  output logic        o_update
);

  localparam logic [4:0] HDR_LAST   = HDR_BITS - 5'd1;
  localparam logic [4:0] FRAME_LAST = FRAME_BITS - 5'd1;

  logic cs_lvl_s, cs_rise_s, cs_fall_s;
  logic sck_lvl_s, sck_rise_s, sck_fall_s;
  logic mosi_lvl_s, mosi_rise_s, mosi_fall_s;
  logic unused_s;

  state_t      state_r, state_nxt_s;
  logic [4:0]  bit_cnt_r;
  logic [15:0] shift_r;
  logic [7:0]  hdr_r;
  logic        rd_active_r;
  logic [15:0] miso_sr_r;
  logic        miso_r;
  logic [15:0] step_r;
  logic [1:0]  scale_r;
  logic        update_r;

  logic        frame_act_s, bit_rise_s, hdr_done_s, frame_done_s, commit_s;
  logic        cs_evt_s;
  logic [7:0]  hdr_byte_s;
  logic [15:0] data_word_s;

  sync_edge #(.IDLE_LVL(1'b1)) u_sync_cs (
    .i_clk(i_clk), .i_rst(i_rst), .i_async(i_spi_cs_n),
    .o_level(cs_lvl_s), .o_rise(cs_rise_s), .o_fall(cs_fall_s)
  );

  sync_edge #(.IDLE_LVL(1'b0)) u_sync_sck (
    .i_clk(i_clk), .i_rst(i_rst), .i_async(i_spi_sck),
    .o_level(sck_lvl_s), .o_rise(sck_rise_s), .o_fall(sck_fall_s)
  );

  sync_edge #(.IDLE_LVL(1'b0)) u_sync_mosi (
    .i_clk(i_clk), .i_rst(i_rst), .i_async(i_spi_mosi),
    .o_level(mosi_lvl_s), .o_rise(mosi_rise_s), .o_fall(mosi_fall_s)
  );

  assign unused_s = ^{sck_lvl_s, mosi_rise_s, mosi_fall_s};

  // CS edges take priority over everything: they end or restart a frame.
  assign cs_evt_s     = cs_rise_s | cs_fall_s;
  assign frame_act_s  = (state_r == ST_HDR) || (state_r == ST_DATA);
  assign bit_rise_s   = sck_rise_s & frame_act_s & ~cs_evt_s;
  assign hdr_done_s   = bit_rise_s & (state_r == ST_HDR) & (bit_cnt_r == HDR_LAST);
  assign frame_done_s = bit_rise_s & (state_r == ST_DATA) & (bit_cnt_r == FRAME_LAST);
  assign hdr_byte_s   = {shift_r[6:0], mosi_lvl_s};
  assign data_word_s  = {shift_r[14:0], mosi_lvl_s};
  assign commit_s     = frame_done_s & ~cs_lvl_s & hdr_r[7];

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: CS rise aborts, CS fall (re)starts, bit count advances phases.
  always_comb begin
    state_nxt_s = state_r;
    if (cs_rise_s) begin
      state_nxt_s = ST_IDLE;
    end else if (cs_fall_s) begin
      state_nxt_s = ST_HDR;
    end else if (hdr_done_s) begin
      state_nxt_s = ST_DATA;
    end else if (frame_done_s) begin
      state_nxt_s = ST_DONE;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Bit counter, MOSI shift-in and header capture at the 8th rising edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bit_cnt_r   <= 5'd0;
      shift_r     <= 16'h0000;
      hdr_r       <= 8'h00;
      rd_active_r <= 1'b0;
    end else if (cs_evt_s) begin
      bit_cnt_r   <= 5'd0;
      shift_r     <= 16'h0000;
      hdr_r       <= 8'h00;
      rd_active_r <= 1'b0;
    end else if (bit_rise_s) begin
      bit_cnt_r <= bit_cnt_r + 5'd1;
      shift_r   <= {shift_r[14:0], mosi_lvl_s};
      if (hdr_done_s) begin
        hdr_r       <= hdr_byte_s;
        rd_active_r <= ~hdr_byte_s[7];
      end
    end
  end

  // Read path: load at end of header, shift one bit out per SCK falling edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      miso_sr_r <= 16'h0000;
      miso_r    <= 1'b0;
    end else if (hdr_done_s) begin
      miso_sr_r <= reg_read(hdr_byte_s[6:0], step_r, scale_r);
      miso_r    <= 1'b0;
    end else if ((state_r != ST_DATA) || !rd_active_r || cs_evt_s) begin
      miso_r <= 1'b0;
    end else if (sck_fall_s) begin
      miso_r    <= miso_sr_r[15];
      miso_sr_r <= {miso_sr_r[14:0], 1'b0};
    end
  end

  // Register commit on the 24th rising edge of a write frame; one-cycle update pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      step_r   <= 16'h0000;
      scale_r  <= 2'b00;
      update_r <= 1'b0;
    end else begin
      update_r <= 1'b0;
      if (commit_s) begin
        case (hdr_r[6:0])
          ADDR_STEP: begin
            step_r   <= data_word_s;
            update_r <= 1'b1;
          end
          ADDR_SCALE: begin
            scale_r  <= data_word_s[1:0];
            update_r <= 1'b1;
          end
          default: update_r <= 1'b0;
        endcase
      end
    end
  end

  assign o_spi_miso = miso_r;
  assign o_step     = step_r;
  assign o_scale    = scale_r;
  assign o_update   = update_r;

endmodule

// File: tb/tb_spi_sinecfg.sv
// Self-checking bench for spi_sinecfg: SCK = i_clk/8, mode 0 master model,
// scoreboard queues for register updates and read-back words.
module tb_spi_sinecfg;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_spi_cs_n = 1'b1;
  logic        i_spi_sck = 1'b0;
  logic        i_spi_mosi = 1'b0;
  logic        o_spi_miso;
  logic [15:0] o_step;
  logic [1:0]  o_scale;
  logic        o_update;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rise24_cyc = 0;
  int upd_count = 0;

  logic [17:0] exp_q[$];
  logic [15:0] rd_q[$];
  logic [17:0] mon_e;
  logic [15:0] model_step = 16'h0000;
  logic [1:0]  model_scale = 2'b00;

  spi_sinecfg dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_spi_cs_n(i_spi_cs_n), .i_spi_sck(i_spi_sck), .i_spi_mosi(i_spi_mosi),
    .o_spi_miso(o_spi_miso), .o_step(o_step), .o_scale(o_scale), .o_update(o_update)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc++;

  // Update monitor: every o_update pulse pops one expected {step, scale} entry.
  always @(negedge i_clk) begin
    if (!i_rst && o_update) begin
      upd_count++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL update_unexpected: got step=%h scale=%b, required no update", o_step, o_scale);
      end else begin
        mon_e = exp_q.pop_front();
        if ({o_step, o_scale} !== mon_e) begin
          errors++;
          $display("FAIL update_value: got %h/%b, required %h/%b", o_step, o_scale, mon_e[17:2], mon_e[1:0]);
        end
        checks++;
        if (cyc - rise24_cyc > 4) begin
          errors++;
          $display("FAIL update_latency: got %0d cycles, required <= 4", cyc - rise24_cyc);
        end
      end
    end
  end

  // Mode-0 master: data changes with SCK low, DUT output sampled at SCK rise.
  task automatic spi_frame(input logic [23:0] word, input int nbits, input int extra,
                           input bit hold_cs, output logic [15:0] rd, output bit hdr_quiet);
    rd = 16'h0000;
    hdr_quiet = 1'b1;
    i_spi_cs_n = 1'b0;
    repeat (6) @(negedge i_clk);
    for (int i = 0; i < nbits; i++) begin
      i_spi_mosi = word[23-i];
      repeat (4) @(negedge i_clk);
      i_spi_sck = 1'b1;
      if (i < 8) begin
        if (o_spi_miso !== 1'b0) hdr_quiet = 1'b0;
      end else begin
        rd = {rd[14:0], o_spi_miso};
      end
      if (i == 23) rise24_cyc = cyc;
      repeat (4) @(negedge i_clk);
      i_spi_sck = 1'b0;
    end
    for (int k = 0; k < extra; k++) begin
      repeat (4) @(negedge i_clk);
      i_spi_sck = 1'b1;
      repeat (4) @(negedge i_clk);
      i_spi_sck = 1'b0;
    end
    i_spi_mosi = 1'b0;
    repeat (4) @(negedge i_clk);
    if (!hold_cs) begin
      i_spi_cs_n = 1'b1;
      repeat (8) @(negedge i_clk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge i_clk);
    checks++;
    if ({o_step, o_scale, o_update, o_spi_miso} !== 20'h00000) begin
      errors++;
      $display("FAIL reset_outputs: got step=%h scale=%b upd=%b miso=%b, required all 0",
               o_step, o_scale, o_update, o_spi_miso);
    end
    i_rst = 1'b0;
    repeat (4) @(negedge i_clk);
  endtask

  task automatic test_write_step();
    logic [15:0] rd;
    bit q;
    int base;
    base = upd_count;
    model_step = 16'h1234;
    exp_q.push_back({model_step, model_scale});
    spi_frame({1'b1, 7'h00, 16'h1234}, 24, 0, 1'b0, rd, q);
    checks++;
    if (upd_count - base !== 1) begin
      errors++;
      $display("FAIL write_step_pulses: got %0d, required 1", upd_count - base);
    end
    checks++;
    if (o_step !== 16'h1234) begin
      errors++;
      $display("FAIL write_step_value: got %h, required 1234", o_step);
    end
    checks++;
    if (o_scale !== 2'b00) begin
      errors++;
      $display("FAIL write_step_scale: got %b, required 00", o_scale);
    end
  endtask

  task automatic test_scale();
    logic [15:0] rd, e;
    bit q;
    model_scale = 2'b11;
    exp_q.push_back({model_step, model_scale});
    spi_frame({1'b1, 7'h01, 16'hFFFF}, 24, 0, 1'b0, rd, q);
    checks++;
    if (o_scale !== 2'b11) begin
      errors++;
      $display("FAIL scale_value: got %b, required 11", o_scale);
    end
    rd_q.push_back({14'h0000, model_scale});
    spi_frame({1'b0, 7'h01, 16'h0000}, 24, 0, 1'b0, rd, q);
    e = rd_q.pop_front();
    checks++;
    if (rd !== e) begin
      errors++;
      $display("FAIL scale_readback: got %h, required %h", rd, e);
    end
  endtask

  task automatic test_read_map();
    logic [6:0]  addrs[4];
    logic [15:0] rd, e;
    bit q;
    addrs = '{7'h7F, 7'h05, 7'h00, 7'h01};
    rd_q.push_back(16'h5A1E);
    rd_q.push_back(16'h0000);
    rd_q.push_back(model_step);
    rd_q.push_back({14'h0000, model_scale});
    for (int i = 0; i < 4; i++) begin
      spi_frame({1'b0, addrs[i], 16'h0000}, 24, 0, 1'b0, rd, q);
      e = rd_q.pop_front();
      checks++;
      if (rd !== e) begin
        errors++;
        $display("FAIL read_addr_%h: got %h, required %h", addrs[i], rd, e);
      end
      checks++;
      if (q !== 1'b1) begin
        errors++;
        $display("FAIL read_hdr_miso_%h: got nonzero MISO in header, required 0", addrs[i]);
      end
      checks++;
      if (o_spi_miso !== 1'b0) begin
        errors++;
        $display("FAIL read_idle_miso_%h: got %b, required 0", addrs[i], o_spi_miso);
      end
    end
  endtask

  task automatic test_partial();
    logic [15:0] rd;
    bit q;
    int base;
    base = upd_count;
    spi_frame({1'b1, 7'h00, 16'hBEEF}, 20, 0, 1'b0, rd, q);
    checks++;
    if (upd_count - base !== 0 || o_step !== model_step) begin
      errors++;
      $display("FAIL partial_discard: got step=%h pulses=%0d, required step=%h pulses=0",
               o_step, upd_count - base, model_step);
    end
    checks++;
    if (o_spi_miso !== 1'b0) begin
      errors++;
      $display("FAIL partial_miso: got %b, required 0", o_spi_miso);
    end
    model_step = 16'h0001;
    exp_q.push_back({model_step, model_scale});
    spi_frame({1'b1, 7'h00, 16'h0001}, 24, 0, 1'b0, rd, q);
    checks++;
    if (o_step !== 16'h0001) begin
      errors++;
      $display("FAIL partial_recover: got %h, required 0001", o_step);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] rd;
    bit q;
    spi_frame({1'b1, 7'h00, 16'h7777}, 12, 0, 1'b1, rd, q);
    @(negedge i_clk);
    i_rst = 1'b1;
    #1;
    model_step = 16'h0000;
    model_scale = 2'b00;
    checks++;
    if ({o_step, o_scale, o_update, o_spi_miso} !== 20'h00000) begin
      errors++;
      $display("FAIL reset_mid_outputs: got step=%h scale=%b upd=%b miso=%b, required all 0",
               o_step, o_scale, o_update, o_spi_miso);
    end
    i_spi_cs_n = 1'b1;
    i_spi_sck = 1'b0;
    repeat (4) @(negedge i_clk);
    i_rst = 1'b0;
    repeat (4) @(negedge i_clk);
    model_step = 16'h0400;
    exp_q.push_back({model_step, model_scale});
    spi_frame({1'b1, 7'h00, 16'h0400}, 24, 0, 1'b0, rd, q);
    checks++;
    if (o_step !== 16'h0400 || o_scale !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid_recover: got %h/%b, required 0400/00", o_step, o_scale);
    end
  endtask

  task automatic test_ignored_writes();
    logic [15:0] rd;
    bit q;
    int base;
    base = upd_count;
    spi_frame({1'b1, 7'h7F, 16'h0000}, 24, 6, 1'b0, rd, q);
    checks++;
    if (upd_count - base !== 0 || o_step !== model_step || o_scale !== model_scale) begin
      errors++;
      $display("FAIL id_write_extra_edges: got %h/%b pulses=%0d, required %h/%b pulses=0",
               o_step, o_scale, upd_count - base, model_step, model_scale);
    end
    spi_frame({1'b1, 7'h22, 16'hFFFF}, 24, 0, 1'b0, rd, q);
    checks++;
    if (upd_count - base !== 0 || o_step !== model_step || o_scale !== model_scale) begin
      errors++;
      $display("FAIL unmapped_write: got %h/%b pulses=%0d, required %h/%b pulses=0",
               o_step, o_scale, upd_count - base, model_step, model_scale);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] rd, e;
    bit q;
    model_step = 16'hA5A5;
    exp_q.push_back({model_step, model_scale});
    spi_frame({1'b1, 7'h00, 16'hA5A5}, 24, 0, 1'b0, rd, q);
    model_scale = 2'b10;
    exp_q.push_back({model_step, model_scale});
    spi_frame({1'b1, 7'h01, 16'h1232}, 24, 0, 1'b0, rd, q);
    rd_q.push_back(model_step);
    spi_frame({1'b0, 7'h00, 16'h0000}, 24, 0, 1'b0, rd, q);
    e = rd_q.pop_front();
    checks++;
    if (rd !== e || o_scale !== 2'b10) begin
      errors++;
      $display("FAIL back_to_back: got rd=%h scale=%b, required rd=%h scale=10", rd, o_scale, e);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending updates, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_write_step();
    test_scale();
    test_read_map();
    test_partial();
    test_reset_mid();
    test_ignored_writes();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_sinecfg.md
SPI_SINECFG -- requirements
Module: spi_sinecfg

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-high reset; port list:
REQ-002 i_clk  input  1  system clock; all state on rising edge; frequency >= 4x SCK frequency.
REQ-003 i_rst  input  1  asynchronous active-high reset.
REQ-004 i_spi_cs_n  input  1  SPI chip select, active low, asynchronous to i_clk.
REQ-005 i_spi_sck  input  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to i_clk.
REQ-006 i_spi_mosi  input  1  SPI data in, MSB first.
REQ-007 o_spi_miso  output  1  SPI data out; driven 0 when not in a read data phase (no tristate).
REQ-008 o_step  output  16  phase-step word for the downstream sine generator.
REQ-009 o_scale  output  2  amplitude right-shift select (shift = 4*o_scale) for the sine generator.
REQ-010 o_update  output  1  one-cycle pulse when o_step or o_scale is written.

Function
REQ-011 i_spi_cs_n, i_spi_sck and i_spi_mosi SHALL each pass through a 2-flop synchronizer; SCK rise/fall and CS fall/rise SHALL be detected from synchronized samples (third flop compare).
REQ-012 Frame: 24 bits while CS low; bits 23..16 header (bit23 = 1 write / 0 read, bits 22..16 address), bits 15..0 data, MSB first.
REQ-013 MOSI SHALL be sampled on each detected SCK rising edge using the synchronized MOSI aligned with the SCK edge sample.
REQ-014 FSM states: IDLE, HDR, DATA, DONE; CS fall -> HDR with bit counter = 0; 8th rising edge in HDR -> DATA; 24th rising edge -> DONE; CS rise in any state -> IDLE.
REQ-015 In DONE further SCK edges SHALL be ignored until CS rises.
REQ-016 Register map: 0x00 STEP (16b, RW); 0x01 SCALE (bits[1:0] RW, bits[15:2] read 0); 0x7F ID (RO, 16'h5A1E); all other addresses read 0, writes ignored.
REQ-017 A write SHALL commit only on the detected 24th SCK rising edge with CS still low; o_step/o_scale update on the next i_clk edge and o_update is high for exactly that one cycle.
REQ-018 Writes to ID or unmapped addresses SHALL not change outputs nor pulse o_update.
REQ-019 Read: at the 8th rising edge the addressed value SHALL be loaded into a 16-bit shift-out register; bit 15 appears on o_spi_miso at the next detected SCK falling edge, each following falling edge shifts one bit, bit 0 held until DONE/IDLE.
REQ-020 CS rising before the 24th rising edge (partial frame) SHALL discard the frame: no register change, no o_update, MISO returns to 0.
REQ-021 CS falling while already in a frame (glitch after a missed rise) SHALL restart in HDR with counter 0.
REQ-022 Pin-to-output latency from 24th raw SCK rising edge to o_step change SHALL be <= 4 i_clk cycles.
REQ-023 Outputs o_step/o_scale SHALL be registered, glitch-free, and change only on commit or reset.

Reset
REQ-024 While i_rst is high: FSM = IDLE, counters 0, o_step = 16'h0000, o_scale = 2'b00, o_update = 0, o_spi_miso = 0, synchronizer flops reset to idle levels (cs_n = 1, sck = 0, mosi = 0).
REQ-025 Reset asserted mid-frame SHALL abort the frame; after release a frame SHALL only start on a fresh CS falling edge.

Structure
REQ-026 A shared package SHALL hold: address constants (STEP 0x00, SCALE 0x01, ID 0x7F), ID value 16'h5A1E, frame/header lengths (24, 8) and the FSM state encoding.
REQ-027 One sub-module sync_edge (2-flop synchronizer + edge detector, outputs level/rise/fall) SHALL be instantiated for SCK, CS and MOSI.

Verification
REQ-028 Write 0x00 data 0x1234 at SCK = i_clk/8 -> o_step = 0x1234 within 4 cycles of 24th edge, o_update exactly one pulse, o_scale unchanged.
REQ-029 Write 0x01 data 0xFFFF -> o_scale = 2'b11; then read 0x01 -> MISO returns 0x0003.
REQ-030 Read 0x7F -> MISO returns 0x5A1E MSB first sampled on SCK rising; read 0x05 -> 0x0000.
REQ-031 Write 0x00 0xBEEF with CS raised after 20 bits -> o_step keeps previous value, no o_update; following full frame 0x00 0x0001 commits correctly.
REQ-032 Assert i_rst mid-write (after 12 bits) -> all outputs to reset values immediately; post-reset frame write 0x00 0x0400 commits.
REQ-033 Write 0x7F 0x0000 and 30 SCK pulses in one CS-low window -> no output change, no o_update, extra edges ignored.
